// File: rtl/adder_share_arbiter_if.sv
// Bundle between the requesters, the shared 8-bit adder and the arbiter.
// The arbiter takes the slave view; the requester/adder side takes the master view.
interface adder_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wide;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    gnt;

  logic [7:0]         add_a;
  logic [7:0]         add_b;
  logic               add_cin;
  logic [7:0]         add_s;
  logic               add_cout;

  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_sum;
  logic               rsp_cout;
  logic               busy;

  modport master (
    output req, req_wide, req_a, req_b, req_cin, add_s, add_cout,
    input  gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req, req_wide, req_a, req_b, req_cin, add_s, add_cout,
    output gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

// File: rtl/adder_share_arbiter.sv
// Time-multiplexes one external 8-bit adder between NREQ requesters with round-robin grant.
// Wide adds run low byte then high byte, chaining the adder's own carry between passes.
module adder_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_share_arbiter_if.slave arb_io
);

  typedef enum logic [1:0] {StIdle, StExecLo, StExecHi} state_e;

  state_e          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      a_hi_q;
  logic [7:0]      b_hi_q;
  logic            wide_q;
  logic [7:0]      lo_q;
  logic [7:0]      add_a_q;
  logic [7:0]      add_b_q;
  logic            add_cin_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     rsp_sum_q;
  logic            rsp_cout_q;

  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr_next;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
  logic            sel_cin;
  logic            sel_wide;

  // Rotating-priority search: candidate k positions past the pointer, first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state_q == StIdle && !rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!gnt_any && arb_io.req[i] && (((32'(ptr_q) + k) % NREQ) == i)) begin
            gnt_any = 1'b1;
            gnt_idx = ID_W'(i);
            gnt[i]  = 1'b1;
          end
        end
      end
    end
  end

  assign ptr_next = ID_W'((32'(gnt_idx) + 32'd1) % NREQ);

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    sel_wide = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a    = arb_io.req_a[16*i +: 16];
        sel_b    = arb_io.req_b[16*i +: 16];
        sel_cin  = arb_io.req_cin[i];
        sel_wide = arb_io.req_wide[i];
      end
    end
  end

  // Adder operands are registered one pass ahead so they are stable for the whole EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      wide_q      <= 1'b0;
      lo_q        <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            id_q      <= gnt_idx;
            ptr_q     <= ptr_next;
            wide_q    <= sel_wide;
            a_hi_q    <= sel_a[15:8];
            b_hi_q    <= sel_b[15:8];
            add_a_q   <= sel_a[7:0];
            add_b_q   <= sel_b[7:0];
            add_cin_q <= sel_cin;
            state_q   <= StExecLo;
          end
        end
        StExecLo: begin
          lo_q <= arb_io.add_s;
          if (wide_q) begin
            add_a_q   <= a_hi_q;
            add_b_q   <= b_hi_q;
            add_cin_q <= arb_io.add_cout;
            state_q   <= StExecHi;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_sum_q   <= {8'h00, arb_io.add_s};
            rsp_cout_q  <= arb_io.add_cout;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StExecHi: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_sum_q   <= {arb_io.add_s, lo_q};
          rsp_cout_q  <= arb_io.add_cout;
          add_a_q     <= '0;
          add_b_q     <= '0;
          add_cin_q   <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign arb_io.gnt       = gnt;
  assign arb_io.add_a     = add_a_q;
  assign arb_io.add_b     = add_b_q;
  assign arb_io.add_cin   = add_cin_q;
  assign arb_io.rsp_valid = rsp_valid_q;
  assign arb_io.rsp_id    = rsp_id_q;
  assign arb_io.rsp_sum   = rsp_sum_q;
  assign arb_io.rsp_cout  = rsp_cout_q;
  assign arb_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: vector table plus a grant-time scoreboard of expected responses.
module tb_adder_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;
  localparam int NVEC = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  adder_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_io (bus)
  );

  typedef struct {
    int          id;
    bit          wide;
    bit          approx;
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    logic [15:0] sum;
    bit          cout;
  } vec_t;

  typedef struct {
    int          id;
    bit          wide;
    logic [15:0] sum;
    bit          cout;
    int          t;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          approx = 1'b0;
  logic [8:0]  lc;
  int          t_g, t_r, t_prev, idx;

  always @(posedge clk) cyc <= cyc + 1;

  // Attached adder: exact, or an approximate variant whose bit 0 is a[0]|b[0].
  function automatic logic [8:0] add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] r;
    r = 9'(a) + 9'(b) + 9'(c);
    if (approx) r[0] = a[0] | b[0];
    return r;
  endfunction

  always_comb {bus.add_cout, bus.add_s} = add8(bus.add_a, bus.add_b, bus.add_cin);

  function automatic exp_t model(input int i);
    exp_t        e;
    logic [15:0] a, b;
    logic [8:0]  r1, r2;
    a  = bus.req_a[16*i +: 16];
    b  = bus.req_b[16*i +: 16];
    r1 = add8(a[7:0], b[7:0], bus.req_cin[i]);
    e.id   = i;
    e.wide = bus.req_wide[i];
    e.t    = cyc;
    if (bus.req_wide[i]) begin
      r2     = add8(a[15:8], b[15:8], r1[8]);
      e.sum  = {r2[7:0], r1[7:0]};
      e.cout = r2[8];
    end else begin
      e.sum  = {8'h00, r1[7:0]};
      e.cout = r1[8];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop/compare responses, push expectations on every transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) check("gnt_while_busy", 32'(bus.gnt), 32'd0);
      if (bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d sum 0x%0h, required no response",
                   bus.rsp_id, bus.rsp_sum);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
          check("sb_rsp_sum", 32'(bus.rsp_sum), 32'(mon_e.sum));
          check("sb_rsp_cout", 32'(bus.rsp_cout), 32'(mon_e.cout));
          check("sb_latency", 32'(cyc - mon_e.t), mon_e.wide ? 32'd3 : 32'd2);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && bus.gnt[i]) sb_q.push_back(model(i));
      end
    end
  end

  task automatic drive(input int i, input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input bit cin);
    bus.req_wide[i]        = wide;
    bus.req_a[16*i +: 16]  = a;
    bus.req_b[16*i +: 16]  = b;
    bus.req_cin[i]         = cin;
    bus.req[i]             = 1'b1;
  endtask

  task automatic clear(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_gnt(input int i, output int t);
    t = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt[i]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout_req%0d: got no grant, required one within 20 cycles", i);
    end
  endtask

  task automatic wait_any(output int id, output int t);
    t  = -1;
    id = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        t = cyc;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) id = i;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_any_timeout: got no grant, required one within 20 cycles");
    end
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: got no rsp_valid, required one within 10 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           id wide apx  a         b         cin sum       cout
    vecs[0]  = '{1, 0, 0, 16'h0035, 16'h004A, 0, 16'h007F, 0};
    vecs[1]  = '{2, 1, 0, 16'h00FF, 16'h0001, 0, 16'h0100, 0};
    vecs[2]  = '{0, 1, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1};
    vecs[3]  = '{3, 0, 0, 16'h0080, 16'h0080, 0, 16'h0000, 1};
    vecs[4]  = '{1, 0, 0, 16'hAB12, 16'hCD34, 1, 16'h0047, 0};
    vecs[5]  = '{0, 1, 0, 16'h1234, 16'h4321, 1, 16'h5556, 0};
    vecs[6]  = '{3, 1, 0, 16'h8000, 16'h8000, 0, 16'h0000, 1};
    vecs[7]  = '{2, 0, 0, 16'h00FF, 16'h00FF, 1, 16'h00FF, 1};
    vecs[8]  = '{1, 1, 0, 16'h7FFF, 16'h0000, 1, 16'h8000, 0};
    vecs[9]  = '{3, 1, 0, 16'h00F0, 16'h0F10, 0, 16'h1000, 0};
    vecs[10] = '{0, 0, 1, 16'h0003, 16'h0001, 0, 16'h0005, 0};
    vecs[11] = '{2, 1, 1, 16'h0102, 16'h0304, 0, 16'h0506, 0};

    rst          = 1'b1;
    bus.req      = '0;
    bus.req_wide = '0;
    bus.req_a    = '0;
    bus.req_b    = '0;
    bus.req_cin  = '0;
    do_reset();

    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_b", 32'(bus.add_b), 32'd0);
    check("rst_add_cin", 32'(bus.add_cin), 32'd0);

    for (int v = 0; v < NVEC; v++) begin
      @(posedge clk);
      #1;
      approx = vecs[v].approx;
      drive(vecs[v].id, vecs[v].wide, vecs[v].a, vecs[v].b, vecs[v].cin);
      wait_gnt(vecs[v].id, t_g);
      if (t_g >= 0) begin
        check($sformatf("v%0d_gnt", v), 32'(bus.gnt), 32'd1 << vecs[v].id);
        @(posedge clk);
        #1 clear(vecs[v].id);
        @(negedge clk);
        check($sformatf("v%0d_lo_add_a", v), 32'(bus.add_a), 32'(vecs[v].a[7:0]));
        check($sformatf("v%0d_lo_add_b", v), 32'(bus.add_b), 32'(vecs[v].b[7:0]));
        check($sformatf("v%0d_lo_add_cin", v), 32'(bus.add_cin), 32'(vecs[v].cin));
        check($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd1);
        if (vecs[v].wide) begin
          lc = 9'(vecs[v].a[7:0]) + 9'(vecs[v].b[7:0]) + 9'(vecs[v].cin);
          @(negedge clk);
          check($sformatf("v%0d_hi_add_a", v), 32'(bus.add_a), 32'(vecs[v].a[15:8]));
          check($sformatf("v%0d_hi_add_b", v), 32'(bus.add_b), 32'(vecs[v].b[15:8]));
          check($sformatf("v%0d_hi_add_cin", v), 32'(bus.add_cin), 32'(lc[8]));
        end
        wait_rsp(t_r);
        if (t_r >= 0) begin
          check($sformatf("v%0d_latency", v), 32'(t_r - t_g), vecs[v].wide ? 32'd3 : 32'd2);
          check($sformatf("v%0d_rsp_id", v), 32'(bus.rsp_id), 32'(vecs[v].id));
          check($sformatf("v%0d_rsp_sum", v), 32'(bus.rsp_sum), 32'(vecs[v].sum));
          check($sformatf("v%0d_rsp_cout", v), 32'(bus.rsp_cout), 32'(vecs[v].cout));
        end
        @(negedge clk);
        check($sformatf("v%0d_rsp_pulse", v), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("v%0d_rsp_hold", v), 32'(bus.rsp_sum), 32'(vecs[v].sum));
      end else begin
        clear(vecs[v].id);
      end
    end
    approx = 1'b0;

    // Round-robin: all four hold narrow requests continuously.
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 16'(8'h11 * (i + 1)), 16'(8'h0F * (i + 3)), 1'b0);
    t_prev = -1;
    for (int g = 0; g < 5; g++) begin
      wait_any(idx, t_g);
      if (t_g >= 0) begin
        check($sformatf("rr_gnt%0d_id", g), 32'(idx), 32'(g % NREQ));
        if (t_prev >= 0) check($sformatf("rr_gnt%0d_gap", g), 32'(t_g - t_prev), 32'd2);
        t_prev = t_g;
      end
    end
    @(posedge clk);
    #1 bus.req = '0;
    repeat (6) @(negedge clk);
    check("rr_sb_drain", 32'(sb_q.size()), 32'd0);

    // Mixed: wide req0 with narrow req3, pointer at 0.
    do_reset();
    @(posedge clk);
    #1;
    drive(0, 1'b1, 16'h12F0, 16'h3420, 1'b0);
    drive(3, 1'b0, 16'h0007, 16'h0009, 1'b1);
    wait_gnt(0, t_g);
    check("mix_first_gnt", 32'(bus.gnt), 32'd1);
    @(posedge clk);
    #1 clear(0);
    wait_gnt(3, t_r);
    check("mix_second_gnt_delay", 32'(t_r - t_g), 32'd3);
    @(posedge clk);
    #1 clear(3);
    repeat (5) @(negedge clk);
    check("mix_sb_drain", 32'(sb_q.size()), 32'd0);

    // Reset during the high pass of a wide add.
    do_reset();
    @(posedge clk);
    #1 drive(2, 1'b1, 16'h1234, 16'h0F0F, 1'b0);
    wait_gnt(2, t_g);
    @(posedge clk);
    #1 clear(2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("midrst_rsp_valid_late", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    drive(3, 1'b0, 16'h0010, 16'h0020, 1'b0);
    drive(1, 1'b0, 16'h0001, 16'h0002, 1'b0);
    wait_gnt(1, t_g);
    check("midrst_first_gnt", 32'(bus.gnt), 32'b0010);
    @(posedge clk);
    #1 clear(1);
    wait_gnt(3, t_r);
    @(posedge clk);
    #1 clear(3);
    repeat (5) @(negedge clk);
    check("final_sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Time-multiplexes one external 8-bit adder, exact or approximate, between NREQ requesters in the Laplace filter datapath.
- Each request is an 8-bit (narrow) or 16-bit (wide) add.
- Wide adds take two passes through the adder: low byte first, then high byte, with the pass-1 carry chained into pass 2.
- A round-robin arbiter grants one requester at a time. The result returns tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request, held high until granted.
- req_wide  input  NREQ  1 = 16-bit add, 0 = 8-bit add.
- req_a  input  NREQ*16  operand A, requester i at bits [16i+15:16i]. Narrow adds use the low byte only.
- req_b  input  NREQ*16  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- gnt  output  NREQ  one-hot acceptance. Transfer occurs when req[i] & gnt[i].
- add_a  output  8  operand byte A to the shared adder.
- add_b  output  8  operand byte B to the shared adder.
- add_cin  output  1  carry-in to the shared adder.
- add_s  input  8  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.
- rsp_valid  output  1  one-cycle result pulse.
- rsp_id  output  ID_W  index of the requester that issued the result.
- rsp_sum  output  16  result; bits [15:8] = 0 for narrow adds.
- rsp_cout  output  1  carry-out of the final pass.
- busy  output  1  high in EXEC_LO and EXEC_HI.

Behaviour:
- Reset (synchronous):
  - state = IDLE, round-robin pointer = 0.
  - gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy all = 0.
  - add_a, add_b, add_cin = 0.
- FSM states: IDLE, EXEC_LO, EXEC_HI.
- IDLE:
  - gnt is combinational. Search req starting at the pointer, wrapping modulo NREQ; the first set bit i wins and gnt[i]=1. No req set means gnt=0.
  - On a grant, at the clock edge:
    - latch A, B, cin, wide, id;
    - pointer <= (i+1) mod NREQ;
    - state <= EXEC_LO.
- EXEC_LO:
  - Drive add_a = A[7:0], add_b = B[7:0], add_cin = cin.
  - At the edge, latch lo <= add_s and c <= add_cout.
  - If wide, state <= EXEC_HI.
  - Otherwise, register the response and state <= IDLE:
    - rsp_sum = {8'h00, add_s};
    - rsp_cout = add_cout;
    - rsp_valid = 1, rsp_id = id.
- EXEC_HI:
  - Drive add_a = A[15:8], add_b = B[15:8], add_cin = c (the latched pass-1 carry).
  - At the edge, register the response and state <= IDLE:
    - rsp_sum = {add_s, lo};
    - rsp_cout = add_cout;
    - rsp_valid = 1.
- Outside the EXEC states, add_a, add_b and add_cin are driven to 0.
- gnt is asserted only in IDLE; never while busy.
- Latency, with grant in cycle T:
  - narrow: rsp_valid high in cycle T+2;
  - wide: rsp_valid high in cycle T+3.
  - The response cycle is an IDLE cycle, so a new grant may occur in that same cycle.
  - Maximum throughput: one narrow add every 2 cycles, or one wide add every 3 cycles.
- rsp_valid is a single-cycle pulse. rsp_id, rsp_sum and rsp_cout hold their values until the next response.
- Carry is passed through from the adder as-is; the block applies no correction.
- Result arithmetic:
  - Wrap-around is modulo 2^8 (narrow) or 2^16 (wide), with overflow reported on rsp_cout.
  - The result is bit-exact to the two-pass composition of whatever adder is attached.
- A requester withdrawing req before gnt is legal; it simply loses arbitration.
- Operands are sampled only in the grant cycle.
- Reset in any state:
  - the in-flight operation is discarded and no rsp_valid is produced;
  - the pointer returns to 0.

Test Plan:
- Narrow: req[1]=1, A=0x0035, B=0x004A, cin=0 -> gnt=4'b0010 at T; at T+2 rsp_valid=1, rsp_id=1, rsp_sum=0x007F, rsp_cout=0.
- Wide carry chain: req[2], wide, A=0x00FF, B=0x0001, cin=0 -> pass 1 add_s=0x00, carry 1; at T+3 rsp_sum=0x0100, rsp_cout=0.
- Wide wrap: A=0xFFFF, B=0x0001 -> rsp_sum=0x0000, rsp_cout=1. Narrow A=0x80, B=0x80 -> rsp_sum=0x0000, rsp_cout=1.
- Round-robin: all four requesters hold narrow req continuously -> grants 0,1,2,3,0 spaced 2 cycles; rsp_id follows the same order.
- Mixed: req[0] wide and req[3] narrow together, pointer=0 -> req[0] granted at T (response T+3), req[3] granted at T+3 (response T+5).
- Reset mid-op: rst asserted during EXEC_HI -> next cycle busy=0, gnt=0, no rsp_valid; first post-reset grant goes to the lowest active index.
